sopc_lan_bus_ctrl: RTL and testbench
====================================

SOPC_LAN_BUS_CTRL -- requirements
Module: sopc_lan_bus_ctrl

Interface
REQ-001 SETUP_CYC, 1, LAN cycles with CS/CMD valid before strobe; range 0..15.
REQ-002 PULSE_CYC, 3, strobe (IOR/IOW) low width in clk cycles; range 1..15.
REQ-003 HOLD_CYC, 1, cycles CS/CMD/write data held after strobe rises; range 0..15.
REQ-004 RECOV_CYC, 2, idle cycles with CS high before the next LAN cycle; range 0..15.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 address  in  2  Avalon word address: 0=index port, 1=data port, 2=status, 3=reserved.
REQ-008 chipselect  in  1  Avalon slave select.
REQ-009 read_n  in  1  Avalon read strobe, active low.
REQ-010 write_n  in  1  Avalon write strobe, active low.
REQ-011 writedata  in  32  Avalon write data; bits 15:0 used for LAN.
REQ-012 readdata  out  32  Avalon read data.
REQ-013 waitrequest  out  1  Avalon stall.
REQ-014 lan_cs_n  out  1  LAN chip select, active low.
REQ-015 lan_cmd  out  1  0=index, 1=data (copy of address[0]).
REQ-016 lan_ior_n / lan_iow_n  out  1 each  LAN read/write strobes, active low.
REQ-017 lan_dout  out  16  LAN write data; lan_doe  out  1  output enable for LAN data pins.
REQ-018 lan_din  in  16  LAN read data; lan_int  in  1  asynchronous LAN interrupt.

Function
REQ-019 Request = chipselect & (~read_n | ~write_n); if both strobes low, the access is a write.
REQ-020 Addresses 2/3 complete with zero wait: waitrequest low in the request cycle, no LAN cycle.
REQ-021 Address 0/1 request: waitrequest high every cycle until the DONE cycle, where it is low for exactly one cycle.
REQ-022 FSM states IDLE, SETUP, STROBE, HOLD, DONE, RECOVER; IDLE accepts an address 0/1 request and moves to SETUP (or STROBE if SETUP_CYC=0).
REQ-023 SETUP: lan_cs_n=0, lan_cmd=address[0], strobes high; lasts SETUP_CYC cycles.
REQ-024 STROBE: lan_ior_n (read) or lan_iow_n (write) low for exactly PULSE_CYC cycles.
REQ-025 Read data: lan_din registered on the clock edge ending the last STROBE cycle; readdata={16'b0,captured} in DONE.
REQ-026 HOLD: cs_n low, strobes high, HOLD_CYC cycles (skipped if 0); DONE: cs_n high, one cycle.
REQ-027 Write: lan_dout=writedata[15:0] and lan_doe=1 from SETUP entry through the last HOLD cycle; lan_doe=0 otherwise.
REQ-028 Address, data and direction latch at IDLE acceptance; later bus changes have no effect until DONE.
REQ-029 RECOVER: RECOV_CYC cycles, cs_n high, new requests stalled (waitrequest high), then IDLE; skipped if 0.
REQ-030 Defaults: request cycle T, waitrequest low at T+6, next LAN cycle may begin at T+9.
REQ-031 lan_int passes a 2-flop synchronizer; status bit0=synced level, bit1=sticky rising-edge flag.
REQ-032 Write to address 2 with writedata[1]=1 clears the sticky flag; a same-cycle new edge wins (flag stays 1).
REQ-033 Status/reserved reads return zeros in all unused bits; address 3 writes are ignored.
REQ-034 Outputs change only on clk edges (all registered) except waitrequest and readdata mux.

Reset
REQ-035 During reset: state=IDLE, lan_cs_n=1, lan_ior_n=1, lan_iow_n=1, lan_doe=0, lan_dout=0, lan_cmd=0, sticky flag and synchronizer=0, captured data=0.
REQ-036 Reset asserted mid-cycle aborts the LAN cycle on the next edge with strobes and CS deasserted; no DONE is issued.

Structure
REQ-037 Package sopc_lan_pkg holds the FSM state enum and address constants (ADDR_INDEX, ADDR_DATA, ADDR_STATUS).
REQ-038 Single sub-module sopc_lan_sync: parameterised-width 2-flop synchronizer with sync reset, used for lan_int.
REQ-039 One shared 4-bit down-counter loaded on each state entry times SETUP/STROBE/HOLD/RECOVER.

Verification
REQ-040 Write addr 0 data 0x0028, defaults -> cs_n low T+1..T+5, iow_n low T+2..T+4, dout=0x0028, doe=1 T+1..T+5, waitrequest low T+6.
REQ-041 Read addr 1, lan_din=0x0A46 -> ior_n low T+2..T+4, readdata=0x00000A46 at T+6, lan_cmd=1 throughout.
REQ-042 Back-to-back writes -> second cs_n falling edge no earlier than 3 cycles after first DONE; cs_n high in between.
REQ-043 SETUP_CYC=0, HOLD_CYC=0, RECOV_CYC=0, PULSE_CYC=1 -> strobe 1 cycle starting T+1, waitrequest low T+2.
REQ-044 lan_int pulse, read addr 2 -> 0x3 then 0x2 after int falls; write 0x2 -> reads 0x0; edge coincident with clear -> reads 0x2.
REQ-045 Reset asserted during STROBE -> next edge cs_n=1, iow_n=1, doe=0, state IDLE; subsequent read completes normally.

Source files
------------

// File: rtl/sopc_lan_pkg.sv
// Shared types and constants for the Avalon-to-LAN-controller bus bridge.
// The FSM state enum, the register addresses and the timing-counter helper.
package sopc_lan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } lan_state_e;

    localparam logic [1:0] ADDR_INDEX  = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CNT_W = 4;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return (cycles == 0) ? '0 : CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sopc_lan_bus_ctrl_if.sv
// Avalon-MM slave bus carried between the system fabric and the LAN bridge.
interface sopc_lan_bus_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/sopc_lan_sync.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk domain.
module sopc_lan_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep both stages sampling the old values, forming a true 2-stage chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sopc_lan_bus_ctrl.sv
// Avalon slave that turns index/data port accesses into timed LAN-controller
// bus cycles, plus a status register carrying the synchronized interrupt.
module sopc_lan_bus_ctrl
    import sopc_lan_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 1,
    parameter int RECOV_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sopc_lan_bus_ctrl_if.slave   av,
    output logic                 lan_cs_n,
    output logic                 lan_cmd,
    output logic                 lan_ior_n,
    output logic                 lan_iow_n,
    output logic [15:0]          lan_dout,
    output logic                 lan_doe,
    input  logic [15:0]          lan_din,
    input  logic                 lan_int
);

    lan_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             is_wr_q, is_wr_nx;
    logic [15:0]      cap_q;

    logic req, req_wr, lan_req, accept;
    logic cs_n_nx, ior_n_nx, iow_n_nx, doe_nx, active_nx;

    logic int_sync, int_sync_d, sticky, int_rise, sticky_clr;
    logic unused_wdata;

    assign req     = av.chipselect & (~av.read_n | ~av.write_n);
    assign req_wr  = ~av.write_n;
    assign lan_req = req & ~av.address[1];
    assign accept  = (state == IDLE) & lan_req;

    assign unused_wdata = ^av.writedata[31:16];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (lan_req) state_nx = (SETUP_CYC != 0) ? SETUP : STROBE;
            SETUP:   if (cnt == '0) state_nx = STROBE;
            STROBE:  if (cnt == '0) state_nx = (HOLD_CYC != 0) ? HOLD : DONE;
            HOLD:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = (RECOV_CYC != 0) ? RECOVER : IDLE;
            RECOVER: if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One shared counter, reloaded whenever a new phase starts.
    always_comb begin
        cnt_nx = (cnt != '0) ? cnt - 1'b1 : '0;
        if (state_nx != state) begin
            case (state_nx)
                SETUP:   cnt_nx = cnt_load(SETUP_CYC);
                STROBE:  cnt_nx = cnt_load(PULSE_CYC);
                HOLD:    cnt_nx = cnt_load(HOLD_CYC);
                RECOVER: cnt_nx = cnt_load(RECOV_CYC);
                default: cnt_nx = '0;
            endcase
        end
    end

    // LAN pins are registered from the next state so they switch exactly on phase edges.
    always_comb begin
        is_wr_nx  = accept ? req_wr : is_wr_q;
        active_nx = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
        cs_n_nx   = ~active_nx;
        ior_n_nx  = ~((state_nx == STROBE) & ~is_wr_nx);
        iow_n_nx  = ~((state_nx == STROBE) &  is_wr_nx);
        doe_nx    = active_nx & is_wr_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_wr_q   <= 1'b0;
            lan_cs_n  <= 1'b1;
            lan_ior_n <= 1'b1;
            lan_iow_n <= 1'b1;
            lan_doe   <= 1'b0;
            lan_dout  <= '0;
            lan_cmd   <= 1'b0;
            cap_q     <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            is_wr_q   <= is_wr_nx;
            lan_cs_n  <= cs_n_nx;
            lan_ior_n <= ior_n_nx;
            lan_iow_n <= iow_n_nx;
            lan_doe   <= doe_nx;
            if (accept) begin
                lan_cmd <= av.address[0];
                if (req_wr) lan_dout <= av.writedata[15:0];
            end
            if ((state == STROBE) && (cnt == '0) && !is_wr_q) cap_q <= lan_din;
        end
    end

    sopc_lan_sync #(.WIDTH(1)) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (lan_int),
        .q     (int_sync)
    );

    assign int_rise   = int_sync & ~int_sync_d;
    assign sticky_clr = req & req_wr & (av.address == ADDR_STATUS) & av.writedata[1];

    // A fresh edge beats a simultaneous clear so no interrupt is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_sync_d <= 1'b0;
            sticky     <= 1'b0;
        end else begin
            int_sync_d <= int_sync;
            if (int_rise)        sticky <= 1'b1;
            else if (sticky_clr) sticky <= 1'b0;
        end
    end

    assign av.waitrequest = lan_req & (state != DONE);

    always_comb begin
        av.readdata = '0;
        case (av.address)
            ADDR_INDEX, ADDR_DATA: av.readdata = {16'b0, cap_q};
            ADDR_STATUS:           av.readdata = {30'b0, sticky, int_sync};
            default:               av.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sopc_lan_bus_ctrl.sv
// Directed bench for sopc_lan_bus_ctrl: default timing instance plus a minimum-timing instance.
module tb_sopc_lan_bus_ctrl;
    import sopc_lan_pkg::*;

    localparam int A_S = 1, A_P = 3, A_H = 1, A_R = 2;
    localparam int B_S = 0, B_P = 1, B_H = 0, B_R = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] lan_din = '0;
    logic lan_int = 1'b0;

    logic a_cs_n, a_cmd, a_ior_n, a_iow_n, a_doe;
    logic [15:0] a_dout;
    logic b_cs_n, b_cmd, b_ior_n, b_iow_n, b_doe;
    logic [15:0] b_dout;

    sopc_lan_bus_ctrl_if ifa ();
    sopc_lan_bus_ctrl_if ifb ();

    sopc_lan_bus_ctrl #(.SETUP_CYC(A_S), .PULSE_CYC(A_P), .HOLD_CYC(A_H), .RECOV_CYC(A_R)) dut_a (
        .clk(clk), .reset(reset), .av(ifa.slave),
        .lan_cs_n(a_cs_n), .lan_cmd(a_cmd), .lan_ior_n(a_ior_n), .lan_iow_n(a_iow_n),
        .lan_dout(a_dout), .lan_doe(a_doe), .lan_din(lan_din), .lan_int(lan_int)
    );

    sopc_lan_bus_ctrl #(.SETUP_CYC(B_S), .PULSE_CYC(B_P), .HOLD_CYC(B_H), .RECOV_CYC(B_R)) dut_b (
        .clk(clk), .reset(reset), .av(ifb.slave),
        .lan_cs_n(b_cs_n), .lan_cmd(b_cmd), .lan_ior_n(b_ior_n), .lan_iow_n(b_iow_n),
        .lan_dout(b_dout), .lan_doe(b_doe), .lan_din(lan_din), .lan_int(lan_int)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];
    int unsigned first_cs_cyc, done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_release();
        ifa.chipselect = 1'b0;
        ifb.chipselect = 1'b0;
        ifa.read_n = 1'b1;  ifb.read_n = 1'b1;
        ifa.write_n = 1'b1; ifb.write_n = 1'b1;
    endtask

    // Entered at 1 time unit after a rising edge; that cycle is request cycle t=0.
    task automatic do_access(input bit sel, input logic [1:0] addr, input bit wr,
                             input logic [31:0] data, input int lat,
                             input logic [31:0] exp_rd, input string tag);
        int s, p, h, t, exp_done;
        bit lan, done, cmd_bad, dout_bad, cs_seen;
        logic cs_n_s, ior_n_s, iow_n_s, doe_s, cmd_s, wait_s;
        logic [15:0] dout_s;
        logic [31:0] m_cs, m_ior, m_iow, m_doe, e_cs, e_stb, rd_obs, rd_exp;
        s = sel ? B_S : A_S;
        p = sel ? B_P : A_P;
        h = sel ? B_H : A_H;
        lan = (addr < 2'd2);
        if (!wr) sb.push_back(exp_rd);
        ifa.address = addr;   ifb.address = addr;
        ifa.writedata = data; ifb.writedata = data;
        ifa.read_n = wr;      ifb.read_n = wr;
        ifa.write_n = !wr;    ifb.write_n = !wr;
        ifa.chipselect = !sel;
        ifb.chipselect = sel;
        m_cs = '0; m_ior = '0; m_iow = '0; m_doe = '0;
        t = 0; done = 0; cmd_bad = 0; dout_bad = 0; cs_seen = 0; rd_obs = '0;
        while (!done && t < 40) begin
            @(negedge clk);
            cs_n_s  = sel ? b_cs_n  : a_cs_n;
            ior_n_s = sel ? b_ior_n : a_ior_n;
            iow_n_s = sel ? b_iow_n : a_iow_n;
            doe_s   = sel ? b_doe   : a_doe;
            cmd_s   = sel ? b_cmd   : a_cmd;
            dout_s  = sel ? b_dout  : a_dout;
            wait_s  = sel ? ifb.waitrequest : ifa.waitrequest;
            if (t < 32) begin
                m_cs[t]  = ~cs_n_s;
                m_ior[t] = ~ior_n_s;
                m_iow[t] = ~iow_n_s;
                m_doe[t] = doe_s;
            end
            if (!cs_n_s && cmd_s !== addr[0]) cmd_bad = 1;
            if (doe_s && dout_s !== data[15:0]) dout_bad = 1;
            if (!cs_n_s && !cs_seen) begin
                cs_seen = 1;
                first_cs_cyc = cyc;
            end
            if (wait_s === 1'b0) begin
                done = 1;
                done_cyc = cyc;
                rd_obs = sel ? ifb.readdata : ifa.readdata;
            end else begin
                @(posedge clk);
                t++;
            end
        end
        @(posedge clk);
        #1;
        bus_release();
        exp_done = lat + (lan ? s + p + h + 1 : 0);
        check({tag, "_done"}, done ? 32'(t) : 32'hFFFF_FFFF, 32'(exp_done));
        for (int i = 0; i < 32; i++) begin
            e_cs[i]  = lan && (i >= lat + 1) && (i <= lat + s + p + h);
            e_stb[i] = lan && (i >= lat + s + 1) && (i <= lat + s + p);
        end
        check({tag, "_cs"}, m_cs, e_cs);
        check({tag, "_strobe"}, wr ? m_iow : m_ior, e_stb);
        check({tag, "_other_strobe"}, wr ? m_ior : m_iow, 32'h0);
        check({tag, "_doe"}, m_doe, wr ? e_cs : 32'h0);
        check({tag, "_cmd"}, 32'(cmd_bad), 32'h0);
        check({tag, "_dout"}, 32'(dout_bad), 32'h0);
        if (!wr) begin
            rd_exp = sb.pop_front();
            check({tag, "_rdata"}, rd_obs, rd_exp);
        end
    endtask

    initial begin
        int unsigned d1;
        ifa.address = '0; ifb.address = '0;
        ifa.writedata = '0; ifb.writedata = '0;
        bus_release();

        // Reset state
        ifa.address = ADDR_STATUS;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(a_cs_n), 32'h1);
        check("rst_ior_n", 32'(a_ior_n), 32'h1);
        check("rst_iow_n", 32'(a_iow_n), 32'h1);
        check("rst_doe", 32'(a_doe), 32'h0);
        check("rst_dout", 32'(a_dout), 32'h0);
        check("rst_cmd", 32'(a_cmd), 32'h0);
        check("rst_status", ifa.readdata, 32'h0);
        check("rst_b_cs_n", 32'(b_cs_n), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Default timing: write index, read data
        do_access(0, 2'd0, 1, 32'hFFFF_0028, 0, 32'h0, "wr_idx");
        idle(A_R);
        lan_din = 16'h0A46;
        do_access(0, 2'd1, 0, 32'h0, 0, 32'h0000_0A46, "rd_data");
        idle(A_R);

        // Back-to-back writes: second request is issued during RECOVER and stalls
        do_access(0, 2'd0, 1, 32'h0000_1111, 0, 32'h0, "b2b_1");
        d1 = done_cyc;
        do_access(0, 2'd1, 1, 32'h0000_2222, A_R, 32'h0, "b2b_2");
        check("b2b_gap", 32'(first_cs_cyc - d1 >= 3), 32'h1);
        idle(A_R);

        // Minimum timing instance
        do_access(1, 2'd0, 1, 32'h0000_BEEF, 0, 32'h0, "min_wr");
        lan_din = 16'h1357;
        do_access(1, 2'd1, 0, 32'h0, 0, 32'h0000_1357, "min_rd");

        // Status and reserved registers
        do_access(0, 2'd3, 0, 32'h0, 0, 32'h0, "rsvd_rd");
        do_access(0, 2'd3, 1, 32'hFFFF_FFFF, 0, 32'h0, "rsvd_wr");
        do_access(0, 2'd2, 0, 32'h0, 0, 32'h0, "st_quiet");
        lan_int = 1'b1;
        idle(4);
        do_access(0, 2'd2, 0, 32'h0, 0, 32'h3, "st_high");
        lan_int = 1'b0;
        idle(4);
        do_access(0, 2'd2, 0, 32'h0, 0, 32'h2, "st_sticky");
        do_access(0, 2'd2, 1, 32'h2, 0, 32'h0, "st_clr");
        do_access(0, 2'd2, 0, 32'h0, 0, 32'h0, "st_cleared");
        // Edge reaches the detector in the same cycle as the clear write
        lan_int = 1'b1;
        idle(2);
        do_access(0, 2'd2, 1, 32'h2, 0, 32'h0, "st_clr_race");
        lan_int = 1'b0;
        idle(4);
        do_access(0, 2'd2, 0, 32'h0, 0, 32'h2, "st_race_wins");
        do_access(0, 2'd2, 1, 32'h1, 0, 32'h0, "st_noclr");
        do_access(0, 2'd2, 0, 32'h0, 0, 32'h2, "st_kept");
        do_access(0, 2'd2, 1, 32'h2, 0, 32'h0, "st_clr2");
        do_access(0, 2'd2, 0, 32'h0, 0, 32'h0, "st_final");

        // Reset in the middle of a write strobe
        idle(2);
        ifa.address = 2'd0;
        ifa.writedata = 32'h0000_00AA;
        ifa.read_n = 1'b1;
        ifa.write_n = 1'b0;
        ifa.chipselect = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_pre_iow", 32'(a_iow_n), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus_release();
        @(posedge clk);
        @(negedge clk);
        check("abort_cs_n", 32'(a_cs_n), 32'h1);
        check("abort_iow_n", 32'(a_iow_n), 32'h1);
        check("abort_doe", 32'(a_doe), 32'h0);
        check("abort_state", 32'(dut_a.state), 32'(IDLE));
        check("abort_wait", 32'(ifa.waitrequest), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        lan_din = 16'h5A5A;
        do_access(0, 2'd1, 0, 32'h0, 0, 32'h0000_5A5A, "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
